// File: rtl/gps_bridge_pkg.sv
// Shared widths, the SPI transmitter state type and sample packing for the GPS-to-MCU bridge.
// The front end delivers 2-bit I and 2-bit Q per clock; four samples make one SPI word.
package gps_bridge_pkg;

    localparam int unsigned SAMPLE_W         = 4;
    localparam int unsigned SAMPLES_PER_WORD = 4;
    localparam int unsigned WORD_W           = SAMPLE_W * SAMPLES_PER_WORD;
    localparam int unsigned SHIFT_CYCLES     = 2 * WORD_W;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap
    } spi_state_e;

    // Sample nibble is {I sign, I mag, Q sign, Q mag}.
    function automatic logic [SAMPLE_W-1:0] pack_sample(input logic i1, input logic i0,
                                                        input logic q1, input logic q0);
        return {i1, i0, q1, q0};
    endfunction

endpackage

// File: rtl/spi_tx_mode0.sv
// Write-only SPI mode-0 transmitter: shifts one word MSB-first at clk/2, then holds SS high
// for GAP cycles before accepting the next word.
module spi_tx_mode0
    import gps_bridge_pkg::*;
#(
    parameter int unsigned GAP = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] word,
    input  logic              valid,
    output logic              sck,
    output logic              ss,
    output logic              mosi,
    output logic              ready
);

    localparam int unsigned GAP_W     = $clog2(GAP + 1);
    localparam int unsigned BIT_CNT_W = $clog2(SHIFT_CYCLES);

    spi_state_e           state_q;
    logic [BIT_CNT_W-1:0] bit_cnt_q;
    logic [GAP_W-1:0]     gap_cnt_q;
    // Holds only the bits not yet on MOSI; the MSB goes straight out at load time.
    logic [WORD_W-2:0]    tx_q;

    // The last gap cycle doubles as the idle check, so back-to-back frames have no idle dwell.
    always_comb begin
        ready = 1'b0;
        if (state_q == StIdle) begin
            ready = 1'b1;
        end else if (state_q == StGap && gap_cnt_q == GAP_W'(GAP)) begin
            ready = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            tx_q      <= '0;
            sck       <= 1'b0;
            ss        <= 1'b1;
            mosi      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StGap: begin
                    if (ready) begin
                        if (valid) begin
                            state_q   <= StShift;
                            bit_cnt_q <= '0;
                            tx_q      <= word[WORD_W-2:0];
                            ss        <= 1'b0;
                            sck       <= 1'b0;
                            mosi      <= word[WORD_W-1];
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                StShift: begin
                    if (bit_cnt_q == BIT_CNT_W'(SHIFT_CYCLES - 1)) begin
                        state_q   <= StGap;
                        gap_cnt_q <= GAP_W'(1);
                        ss        <= 1'b1;
                        sck       <= 1'b0;
                        mosi      <= 1'b0;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (!bit_cnt_q[0]) begin
                            sck <= 1'b1;
                        end else begin
                            // Falling SCK edge: present the next bit while SCK is low.
                            sck  <= 1'b0;
                            mosi <= tx_q[WORD_W-2];
                            tx_q <= {tx_q[WORD_W-3:0], 1'b0};
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ss      <= 1'b1;
                    sck     <= 1'b0;
                    mosi    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/gps_spi_bridge.sv
// GPS front-end to MCU bridge: decimates 4-bit I/Q samples, packs four per 16-bit word and
// streams each word over write-only SPI mode 0. Also forwards the front-end clock.
module gps_spi_bridge
    import gps_bridge_pkg::*;
#(
    parameter int unsigned DECIM = 10,
    parameter int unsigned GAP   = 8
) (
    input  logic GPS_CLK_16_368,
    input  logic RESET,
    input  logic GPS_I0,
    input  logic GPS_I1,
    input  logic GPS_Q0,
    input  logic GPS_Q1,
    output logic MCU_SCK,
    output logic MCU_SS,
    output logic MCU_MOSI,
    output logic GPS_CLK_16_OUT
);

    localparam int unsigned DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned PCNT_W = $clog2(SAMPLES_PER_WORD);

    logic                clk;
    logic [DCNT_W-1:0]   dcnt_q;
    logic [PCNT_W-1:0]   pack_cnt_q;
    logic [WORD_W-1:0]   pack_q;
    logic                word_done_q;
    logic [WORD_W-1:0]   hold_q;
    logic                hold_valid_q;
    logic                tx_ready;
    logic                capture;
    logic [SAMPLE_W-1:0] sample;

    assign clk            = GPS_CLK_16_368;
    assign GPS_CLK_16_OUT = GPS_CLK_16_368;

    assign capture = (dcnt_q == '0);
    assign sample  = pack_sample(GPS_I1, GPS_I0, GPS_Q1, GPS_Q0);

    always_ff @(posedge clk) begin
        if (RESET) begin
            dcnt_q       <= '0;
            pack_cnt_q   <= '0;
            pack_q       <= '0;
            word_done_q  <= 1'b0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            dcnt_q      <= (dcnt_q == DCNT_W'(DECIM - 1)) ? '0 : dcnt_q + 1'b1;
            word_done_q <= 1'b0;

            if (capture) begin
                pack_q     <= {pack_q[WORD_W-SAMPLE_W-1:0], sample};
                pack_cnt_q <= pack_cnt_q + 1'b1;
                if (pack_cnt_q == PCNT_W'(SAMPLES_PER_WORD - 1)) begin
                    word_done_q <= 1'b1;
                end
            end

            // A full holding register keeps the older word; the transmitter taking it this
            // cycle frees the slot for the new one.
            if (word_done_q && (!hold_valid_q || tx_ready)) begin
                hold_q       <= pack_q;
                hold_valid_q <= 1'b1;
            end else if (tx_ready) begin
                hold_valid_q <= 1'b0;
            end
        end
    end

    spi_tx_mode0 #(
        .GAP (GAP)
    ) u_spi_tx (
        .clk   (clk),
        .rst   (RESET),
        .word  (hold_q),
        .valid (hold_valid_q),
        .sck   (MCU_SCK),
        .ss    (MCU_SS),
        .mosi  (MCU_MOSI),
        .ready (tx_ready)
    );

endmodule

// File: tb/tb_gps_spi_bridge.sv
// Bench for gps_spi_bridge: a closed-form frame-schedule model checked every cycle, an
// MCU-side SPI receiver, and literal expectations for the directed scenarios.
module tb_gps_spi_bridge;

    localparam int unsigned DECIM = 10;
    localparam int unsigned GAP   = 8;

    logic clk = 1'b0;
    logic RESET = 1'b1;
    logic GPS_I0 = 1'b0, GPS_I1 = 1'b0, GPS_Q0 = 1'b0, GPS_Q1 = 1'b0;
    logic MCU_SCK, MCU_SS, MCU_MOSI, GPS_CLK_16_OUT;

    int errors = 0;
    int checks = 0;

    gps_spi_bridge #(
        .DECIM (DECIM),
        .GAP   (GAP)
    ) dut (
        .GPS_CLK_16_368 (clk),
        .RESET          (RESET),
        .GPS_I0         (GPS_I0),
        .GPS_I1         (GPS_I1),
        .GPS_Q0         (GPS_Q0),
        .GPS_Q1         (GPS_Q1),
        .MCU_SCK        (MCU_SCK),
        .MCU_SS         (MCU_SS),
        .MCU_MOSI       (MCU_MOSI),
        .GPS_CLK_16_OUT (GPS_CLK_16_OUT)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input int got, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, got, got, exp, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] v);
        {GPS_I1, GPS_I0, GPS_Q1, GPS_Q0} = v;
    endtask

    // Input nibble seen at each edge of the current reset-free segment.
    logic [3:0] samp [0:1023];
    int cyc = -1;

    // Frame n starts 3*DECIM+2 cycles after release plus n frame periods; within a frame,
    // offset o shows bit 15-o/2 of the word built from the four captures at 4nD..4nD+3D.
    function automatic logic [2:0] model(input int c);
        int base, n, o;
        logic [15:0] w;
        base = 3 * DECIM + 2;
        if (c < base) return 3'b100;
        n = (c - base) / (4 * DECIM);
        o = (c - base) % (4 * DECIM);
        if (o >= 32) return 3'b100;
        w = {samp[4*n*DECIM], samp[(4*n+1)*DECIM], samp[(4*n+2)*DECIM], samp[(4*n+3)*DECIM]};
        return {1'b0, o[0], w[15-o/2]};
    endfunction

    // MCU-side receiver state.
    logic        prev_ss = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0;
    logic [15:0] rx_sh = '0;
    logic [15:0] seg_words [$];
    int          rises = 0, high_run = 0, last_fall = 0, first_fall_cyc = -1;
    bit          seg_first = 1'b1, in_frame = 1'b0;

    always @(posedge clk) begin
        logic       rst_edge;
        logic [2:0] exp_o, got_o;
        rst_edge = RESET;
        if (rst_edge) begin
            cyc = -1;
        end else begin
            cyc++;
            if (cyc < 1024) samp[cyc] = {GPS_I1, GPS_I0, GPS_Q1, GPS_Q0};
        end
        #1;
        exp_o = model(cyc);
        got_o = {MCU_SS, MCU_SCK, MCU_MOSI};
        chk(got_o === exp_o, "ss_sck_mosi", int'(got_o), int'(exp_o));

        if (rst_edge) begin
            seg_first      = 1'b1;
            in_frame       = 1'b0;
            high_run       = 0;
            first_fall_cyc = -1;
            seg_words.delete();
        end else begin
            if (prev_ss && !MCU_SS) begin
                if (seg_first) begin
                    first_fall_cyc = cyc;
                    seg_first      = 1'b0;
                end else begin
                    chk(cyc - last_fall == 40, "ss_period", cyc - last_fall, 40);
                    chk(high_run == 8, "ss_high_len", high_run, 8);
                end
                last_fall = cyc;
                rises     = 0;
                rx_sh     = '0;
                in_frame  = 1'b1;
            end
            if (!MCU_SS && !prev_sck && MCU_SCK) begin
                chk(MCU_MOSI === prev_mosi, "mosi_stable", int'(MCU_MOSI), int'(prev_mosi));
                rx_sh = {rx_sh[14:0], MCU_MOSI};
                rises++;
            end
            if (!prev_ss && MCU_SS && in_frame) begin
                chk(rises == 16, "sck_rises", rises, 16);
                seg_words.push_back(rx_sh);
                in_frame = 1'b0;
            end
        end
        if (MCU_SS) high_run++;
        else high_run = 0;
        prev_ss   = MCU_SS;
        prev_sck  = MCU_SCK;
        prev_mosi = MCU_MOSI;
    end

    // Forwarded clock must track the input on both edges, reset or not.
    initial forever begin
        @(clk);
        #1;
        chk(GPS_CLK_16_OUT === clk, "clk_passthru", int'(GPS_CLK_16_OUT), int'(clk));
    end

    task automatic wait_words(input int n, input int budget, input string name);
        int i;
        for (i = 0; i < budget && seg_words.size() < n; i++) @(negedge clk);
        chk(seg_words.size() >= n, name, seg_words.size(), n);
    endtask

    function automatic logic [3:0] pattern(input int t);
        int v;
        if (t < 40) v = t / 10 + 1;
        else v = (t * 7 + 3) % 16;
        return v[3:0];
    endfunction

    initial begin
        // Reset held with toggling inputs; the per-cycle model expects idle outputs.
        RESET = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(4'(i * 5 + 3));
            @(negedge clk);
        end

        // Constant I1=1 I0=0 Q1=1 Q0=1.
        RESET = 1'b0;
        drive(4'hB);
        wait_words(2, 300, "const_words_timeout");
        chk(first_fall_cyc == 32, "first_ss_fall", first_fall_cyc, 32);
        if (seg_words.size() >= 2) begin
            chk(seg_words[0] == 16'hBBBB, "const_word0", int'(seg_words[0]), 'hBBBB);
            chk(seg_words[1] == 16'hBBBB, "const_word1", int'(seg_words[1]), 'hBBBB);
        end

        // One value per decimation window, then a continuous varying run.
        @(negedge clk);
        RESET = 1'b1;
        @(negedge clk);
        RESET = 1'b0;
        for (int t = 0; t < 440; t++) begin
            drive(pattern(t));
            @(negedge clk);
        end
        chk(first_fall_cyc == 32, "seq_first_fall", first_fall_cyc, 32);
        chk(seg_words.size() == 10, "seq_word_count", seg_words.size(), 10);
        if (seg_words.size() >= 1)
            chk(seg_words[0] == 16'h1234, "seq_word0", int'(seg_words[0]), 'h1234);

        // Reset lands on offset 15 of frame 10 (which starts at cycle 432).
        for (int t = 440; t < 447; t++) begin
            drive(pattern(t));
            @(negedge clk);
        end
        RESET = 1'b1;
        drive(4'h9);
        @(posedge clk);
        #2;
        chk(MCU_SS === 1'b1, "abort_ss", int'(MCU_SS), 1);
        chk(MCU_SCK === 1'b0, "abort_sck", int'(MCU_SCK), 0);
        @(negedge clk);
        @(negedge clk);
        RESET = 1'b0;
        drive(4'hC);
        wait_words(1, 200, "post_reset_timeout");
        chk(first_fall_cyc == 32, "post_reset_fall", first_fall_cyc, 32);
        if (seg_words.size() >= 1)
            chk(seg_words[0] == 16'hCCCC, "post_reset_word", int'(seg_words[0]), 'hCCCC);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
